// File: rtl/alu_seq_if.sv
// Operand-issue / result handshake bundle for alu_seq.
// The slave modport is the ALU side; the master modport is the issue/consumer side.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic                 i_valid;
    logic                 o_ready;
    logic [WIDTH-1:0]     i_op1;
    logic [WIDTH-1:0]     i_op2;
    logic [2:0]           i_ctrl;
    logic                 o_valid;
    logic                 i_ready;
    logic [2*WIDTH-1:0]   o_dat;
    logic                 o_carry;
    logic                 o_zero;
    logic                 o_err;

    modport slave (
        input  i_valid, i_op1, i_op2, i_ctrl, i_ready,
        output o_ready, o_valid, o_dat, o_carry, o_zero, o_err
    );

    modport master (
        output i_valid, i_op1, i_op2, i_ctrl, i_ready,
        input  o_ready, o_valid, o_dat, o_carry, o_zero, o_err
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: ADD/SUB/NAND/NOR complete in one cycle, MUL runs a
// WIDTH-step shift-add loop. One operation in flight, valid/ready on both sides.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int RW    = 2 * WIDTH;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    typedef struct packed {
        logic [RW-1:0] dat;
        logic          carry;
        logic          err;
    } res_t;

    state_t           state;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    logic             valid_q;
    logic [RW-1:0]    dat_q;
    logic             carry_q;
    logic             zero_q;
    logic             err_q;

    logic             accept;
    res_t             alu_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [RW-1:0]    acc_next;

    assign bus.o_ready = (state == IDLE) && !i_rst;
    assign accept      = bus.i_valid && bus.o_ready;

    assign bus.o_valid = valid_q;
    assign bus.o_dat   = dat_q;
    assign bus.o_carry = carry_q;
    assign bus.o_zero  = zero_q;
    assign bus.o_err   = err_q;

    // Single-cycle ops, evaluated straight off the issue bus for capture at accept.
    assign sum  = {1'b0, bus.i_op1} + {1'b0, bus.i_op2};
    assign diff = {1'b0, bus.i_op1} - {1'b0, bus.i_op2};

    always_comb begin
        alu_res = '0;
        case (bus.i_ctrl)
            OP_ADD: begin
                alu_res.dat[WIDTH:0] = sum;
                alu_res.carry        = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res.dat[WIDTH-1:0] = diff[WIDTH-1:0];
                alu_res.carry          = diff[WIDTH];
            end
            OP_MUL:  alu_res = '0;
            OP_NAND: alu_res.dat[WIDTH-1:0] = ~(bus.i_op1 & bus.i_op2);
            OP_NOR:  alu_res.dat[WIDTH-1:0] = ~(bus.i_op1 | bus.i_op2);
            default: alu_res.err = 1'b1;
        endcase
    end

    // One partial product per cycle; multiplicand walks left as multiplier walks right.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            dat_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.i_ctrl == OP_MUL) begin
                            state  <= MUL;
                            acc    <= '0;
                            cnt    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, bus.i_op1};
                            mplier <= bus.i_op2;
                        end else begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                            dat_q   <= alu_res.dat;
                            carry_q <= alu_res.carry;
                            zero_q  <= (alu_res.dat == '0);
                            err_q   <= alu_res.err;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                        dat_q   <= acc_next;
                        carry_q <= 1'b0;
                        zero_q  <= (acc_next == '0);
                        err_q   <= 1'b0;
                    end
                end
                DONE: begin
                    // Result registers hold after release until the next load.
                    if (bus.i_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand-written backpressure/reset
// sequences, a WIDTH=8 multiply, and random ops against an arithmetic model.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(4)) a4 ();
    alu_seq_if #(.WIDTH(8)) a8 ();

    alu_seq #(.WIDTH(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(a4.slave));
    alu_seq #(.WIDTH(8)) dut8 (.i_clk(clk), .i_rst(rst), .bus(a8.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        int         hold;
        logic [7:0] dat;
        logic       c;
        logic       z;
        logic       e;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on a 4-bit operand width.
    function automatic vec_t model(input int op, input int a, input int b, input int hold);
        vec_t v;
        int   d;
        v.op = 3'(op); v.a = 4'(a); v.b = 4'(b); v.hold = hold;
        v.c = 1'b0; v.e = 1'b0; d = 0;
        case (op)
            0: begin d = a + b; v.c = (a + b) > 15; end
            1: begin d = (a - b + 16) % 16; v.c = a < b; end
            2: d = a * b;
            3: d = 15 - (a & b);
            4: d = 15 - (a | b);
            default: v.e = 1'b1;
        endcase
        v.dat = 8'(d);
        v.z   = (d == 0);
        v.lat = (op == 2) ? 5 : 1;
        return v;
    endfunction

    // Issue one op on the WIDTH=4 DUT, wait for its result, hold off i_ready
    // for 'hold' cycles, then release and observe o_valid drop.
    task automatic run4(input vec_t v, input string tag);
        int         n;
        int         lat;
        logic [7:0] dat;
        logic       c, z, e;
        bit         busy_ok, held_ok;
        @(negedge clk);
        n = 0;
        while (!a4.o_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, ".ready_before"}, 32'(a4.o_ready), 32'd1);
        a4.i_valid = 1'b1; a4.i_ctrl = v.op; a4.i_op1 = v.a; a4.i_op2 = v.b;
        a4.i_ready = (v.hold == 0);
        @(posedge clk); #1;
        a4.i_valid = 1'b0;
        a4.i_op1 = 4'($urandom); a4.i_op2 = 4'($urandom); a4.i_ctrl = 3'($urandom);
        lat = 1; busy_ok = 1'b1;
        while (!a4.o_valid && lat < 40) begin
            if (a4.o_ready) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        dat = a4.o_dat; c = a4.o_carry; z = a4.o_zero; e = a4.o_err;
        chk({tag, ".lat"}, 32'(lat), 32'(v.lat));
        chk({tag, ".busy_ready_low"}, 32'(busy_ok), 32'd1);
        chk({tag, ".dat"}, 32'(dat), 32'(v.dat));
        chk({tag, ".carry"}, 32'(c), 32'(v.c));
        chk({tag, ".zero"}, 32'(z), 32'(v.z));
        chk({tag, ".err"}, 32'(e), 32'(v.e));
        held_ok = 1'b1;
        repeat (v.hold) begin
            @(posedge clk); #1;
            if (!a4.o_valid || a4.o_dat !== dat || a4.o_ready) held_ok = 1'b0;
        end
        if (v.hold > 0) begin
            chk({tag, ".held"}, 32'(held_ok), 32'd1);
            @(negedge clk); a4.i_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, ".released"}, {30'd0, a4.o_valid, a4.o_ready}, 32'b01);
        chk({tag, ".dat_after"}, 32'(a4.o_dat), 32'(v.dat));
        a4.i_ready = 1'b0;
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        a4.i_valid = 0; a4.i_op1 = 0; a4.i_op2 = 0; a4.i_ctrl = 0; a4.i_ready = 0;
        a8.i_valid = 0; a8.i_op1 = 0; a8.i_op2 = 0; a8.i_ctrl = 0; a8.i_ready = 0;
        rst = 1'b1;

        //            op    a     b    hold dat    c  z  e  lat
        vecs.push_back('{3'd0, 4'd9,  4'd8,  0, 8'h11, 1, 0, 0, 1});
        vecs.push_back('{3'd1, 4'd3,  4'd5,  0, 8'h0E, 1, 0, 0, 1});
        vecs.push_back('{3'd1, 4'd5,  4'd5,  0, 8'h00, 0, 1, 0, 1});
        vecs.push_back('{3'd2, 4'd15, 4'd15, 0, 8'hE1, 0, 0, 0, 5});
        vecs.push_back('{3'd3, 4'hC,  4'hA,  0, 8'h07, 0, 0, 0, 1});
        vecs.push_back('{3'd4, 4'hC,  4'hA,  1, 8'h01, 0, 0, 0, 1});
        vecs.push_back('{3'd6, 4'd3,  4'd4,  0, 8'h00, 0, 1, 1, 1});
        vecs.push_back('{3'd0, 4'd15, 4'd15, 2, 8'h1E, 1, 0, 0, 1});
        vecs.push_back('{3'd2, 4'd0,  4'd7,  0, 8'h00, 0, 1, 0, 5});
        vecs.push_back('{3'd1, 4'd0,  4'd1,  0, 8'h0F, 1, 0, 0, 1});
        vecs.push_back('{3'd5, 4'd1,  4'd1,  2, 8'h00, 0, 1, 1, 1});
        vecs.push_back('{3'd2, 4'd13, 4'd11, 3, 8'h8F, 0, 0, 0, 5});
        vecs.push_back('{3'd7, 4'd9,  4'd2,  0, 8'h00, 0, 1, 1, 1});

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("rst.ready", 32'(a4.o_ready), 32'd0);
        chk("rst.outs", {a4.o_valid, a4.o_carry, a4.o_zero, a4.o_err, 8'(a4.o_dat)}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst.ready_release", 32'(a4.o_ready), 32'd1);

        foreach (vecs[i]) run4(vecs[i], $sformatf("vec%0d", i));

        // Backpressure with a pending issue that must be ignored until IDLE
        @(negedge clk);
        a4.i_valid = 1'b1; a4.i_ctrl = 3'd0; a4.i_op1 = 4'd2; a4.i_op2 = 4'd3; a4.i_ready = 1'b0;
        @(posedge clk); #1;
        a4.i_ctrl = 3'd1; a4.i_op1 = 4'd7; a4.i_op2 = 4'd1;
        begin
            bit ok = 1'b1;
            repeat (5) begin
                if (!a4.o_valid || a4.o_dat !== 8'h05 || a4.o_ready) ok = 1'b0;
                @(posedge clk); #1;
            end
            chk("bp.hold", 32'(ok), 32'd1);
        end
        @(negedge clk); a4.i_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release", {30'd0, a4.o_valid, a4.o_ready}, 32'b01);
        @(posedge clk); #1;
        a4.i_valid = 1'b0;
        chk("bp.next_valid", 32'(a4.o_valid), 32'd1);
        chk("bp.next_dat", 32'(a4.o_dat), 32'h06);
        @(posedge clk); #1;
        a4.i_ready = 1'b0;

        // Reset during the second MUL cycle
        run4(model(0, 9, 8, 0), "pre_rst");
        @(negedge clk);
        a4.i_valid = 1'b1; a4.i_ctrl = 3'd2; a4.i_op1 = 4'd15; a4.i_op2 = 4'd15;
        @(posedge clk); #1;
        a4.i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst.outs", {a4.o_valid, a4.o_carry, a4.o_zero, a4.o_err, 8'(a4.o_dat)}, 32'd0);
        chk("mrst.ready_in_rst", 32'(a4.o_ready), 32'd0);
        rst = 1'b0; #1;
        chk("mrst.ready", 32'(a4.o_ready), 32'd1);
        run4(model(0, 1, 1, 0), "post_rst");

        // WIDTH=8 max*max
        @(negedge clk);
        a8.i_valid = 1'b1; a8.i_ctrl = 3'd2; a8.i_op1 = 8'hFF; a8.i_op2 = 8'hFF; a8.i_ready = 1'b1;
        @(posedge clk); #1;
        a8.i_valid = 1'b0;
        begin
            int lat = 1;
            while (!a8.o_valid && lat < 40) begin @(posedge clk); #1; lat++; end
            chk("w8.lat", 32'(lat), 32'd9);
            chk("w8.dat", 32'(a8.o_dat), 32'hFE01);
            chk("w8.flags", {29'd0, a8.o_carry, a8.o_zero, a8.o_err}, 32'd0);
        end
        @(posedge clk); #1;
        chk("w8.release", 32'(a8.o_valid), 32'd0);

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            v = model($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 2));
            run4(v, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
